// File: rtl/spi_master_if.sv
// -----------------------------------------------------------------------------
// spi_master_if
//
// SPI bus master. Each accepted host request is sent as one frame of
// 1 + ADDRESS_WIDTH + DATA_WIDTH bits, MSB first: the command bit (rd_we),
// then the address, then the data field. All four CPOL/CPHA modes are
// supported. The SCK half-period is programmable through `divider`.
// For reads, the slave's data word is returned on data_read together with a
// one-cycle data_read_valid strobe.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous, active-high reset
//   data             write data, latched when a request is accepted
//   address          target address, latched when a request is accepted
//   enable           request strobe; ignored while busy
//   rd_we            1 = write, 0 = read; latched with the request
//   divider          SCK half-period in clock cycles (0 behaves as 1)
//   clock_phase      CPHA, latched with the request
//   clock_polarity   CPOL; SCK follows it live while idle
//   MISO             serial data from the slave
//   SCK              serial clock
//   data_read        last word read from the slave
//   busy             a frame is in progress
//   SS               slave select, active-low
//   MOSI             serial data to the slave
//   data_read_valid  one-cycle pulse when data_read is updated
// -----------------------------------------------------------------------------
module spi_master_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    data,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     enable,
    input  logic                     rd_we,
    input  logic [15:0]              divider,
    input  logic                     clock_phase,
    input  logic                     clock_polarity,
    input  logic                     MISO,
    output logic                     SCK,
    output logic [DATA_WIDTH-1:0]    data_read,
    output logic                     busy,
    output logic                     SS,
    output logic                     MOSI,
    output logic                     data_read_valid
);

    // -------------------------------------------------------------------------
    // Frame geometry
    // -------------------------------------------------------------------------
    localparam int FRAME_BITS = 1 + ADDRESS_WIDTH + DATA_WIDTH;
    localparam int EDGE_TOTAL = 2 * FRAME_BITS;
    localparam int EDGE_W     = $clog2(EDGE_TOTAL + 1);

    // edge_cnt holds the number of SCK edges already produced, so the edge
    // being generated on a tick is edge number edge_cnt + 1.
    localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(EDGE_TOTAL - 1);
    // First edge count that belongs to the data field (bit index 1+AW).
    localparam logic [EDGE_W-1:0] DATA_EDGE  = EDGE_W'(2 * (1 + ADDRESS_WIDTH));

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_END
    } state_t;

    state_t state;
    state_t state_next;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [15:0]             div_q;      // effective half-period, never 0
    logic [15:0]             div_cnt;    // cycles elapsed in current half-period
    logic [EDGE_W-1:0]       edge_cnt;
    logic                    phase;      // SCK = cpol_q ^ phase while active
    logic                    cpol_q;
    logic                    cpha_q;
    logic                    write_q;
    logic [FRAME_BITS-1:0]   shift_out;
    logic [DATA_WIDTH-1:0]   shift_in;
    logic                    mosi_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   data_read_q;
    logic                    valid_q;

    // -------------------------------------------------------------------------
    // Combinational strobes
    // -------------------------------------------------------------------------
    logic                    accept;
    logic                    tick;
    logic                    leading;
    logic                    last_edge;
    logic                    shift_en;
    logic                    sample_en;
    logic                    end_done;
    logic [DATA_WIDTH-1:0]   data_field;
    logic [FRAME_BITS-1:0]   frame_load;
    logic [15:0]             div_eff;

    // NOTE: every signal written in an always_comb block gets a default value
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        accept     = 1'b0;
        tick       = 1'b0;
        leading    = 1'b0;
        last_edge  = 1'b0;
        shift_en   = 1'b0;
        sample_en  = 1'b0;
        end_done   = 1'b0;
        data_field = '0;
        frame_load = '0;
        div_eff    = divider;

        if (divider == 16'd0) begin
            div_eff = 16'd1;
        end

        // A read carries zeros in the data field on MOSI.
        if (rd_we) begin
            data_field = data;
        end
        frame_load = {rd_we, address, data_field};

        accept    = (state == S_IDLE) && enable;
        tick      = (state != S_IDLE) && (div_cnt == div_q - 16'd1);
        // Odd-numbered edges (1, 3, ...) are leading edges.
        leading   = ~edge_cnt[0];
        last_edge = (edge_cnt == LAST_EDGE);

        if ((state == S_ACTIVE) && tick) begin
            if (cpha_q) begin
                // CPHA=1: advance on leading, sample on trailing.
                shift_en  = leading;
                sample_en = ~leading;
            end else begin
                // CPHA=0: sample on leading, advance on trailing except the
                // last, which would otherwise push a bit past the frame.
                shift_en  = ~leading && !last_edge;
                sample_en = leading;
            end
            // MISO only matters for the data field of a read.
            sample_en = sample_en && !write_q && (edge_cnt >= DATA_EDGE);
        end

        end_done = (state == S_END) && tick;
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (tick && last_edge) begin
                    state_next = S_END;
                end
            end
            S_END: begin
                if (tick) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of the
    // order statements appear in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q       <= 16'd1;
            div_cnt     <= '0;
            edge_cnt    <= '0;
            phase       <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            write_q     <= 1'b0;
            shift_out   <= '0;
            shift_in    <= '0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            data_read_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            if (accept) begin
                div_q    <= div_eff;
                div_cnt  <= '0;
                edge_cnt <= '0;
                phase    <= 1'b0;
                cpol_q   <= clock_polarity;
                cpha_q   <= clock_phase;
                write_q  <= rd_we;
                shift_in <= '0;
                busy_q   <= 1'b1;
                if (clock_phase) begin
                    // First bit goes out on the first leading edge.
                    mosi_q    <= 1'b0;
                    shift_out <= frame_load;
                end else begin
                    // Command bit must be on the wire as SS falls.
                    mosi_q    <= frame_load[FRAME_BITS-1];
                    shift_out <= {frame_load[FRAME_BITS-2:0], 1'b0};
                end
            end else if (state != S_IDLE) begin
                if (tick) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end

                if ((state == S_ACTIVE) && tick) begin
                    phase    <= ~phase;
                    edge_cnt <= edge_cnt + 1'b1;
                end

                if (shift_en) begin
                    mosi_q    <= shift_out[FRAME_BITS-1];
                    shift_out <= {shift_out[FRAME_BITS-2:0], 1'b0};
                end

                if (sample_en) begin
                    shift_in <= {shift_in[DATA_WIDTH-2:0], MISO};
                end

                if (end_done) begin
                    busy_q <= 1'b0;
                    mosi_q <= 1'b0;
                    if (!write_q) begin
                        data_read_q <= shift_in;
                        valid_q     <= 1'b1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // While idle SCK tracks the live polarity input so the bus parks at the
    // level the next frame will use; phase is 0 in END, so SCK is idle there.
    assign SCK             = (state == S_IDLE) ? clock_polarity : (cpol_q ^ phase);
    assign SS              = ~busy_q;
    assign busy            = busy_q;
    assign MOSI            = mosi_q;
    assign data_read       = data_read_q;
    assign data_read_valid = valid_q;

endmodule

// File: tb/tb_spi_master_if.sv
// -----------------------------------------------------------------------------
// tb_spi_master_if
//
// Drives directed requests into spi_master_if. A behavioural SPI slave with a
// small word memory answers on MISO and captures MOSI. Each request pushes its
// expected frame into a scoreboard; a monitor pops and compares whenever SS
// rises (end of frame), including the valid strobe and data_read.
// -----------------------------------------------------------------------------
module tb_spi_master_if;

    logic        clock;
    logic        reset;
    logic [31:0] data;
    logic [31:0] address;
    logic        enable;
    logic        rd_we;
    logic [15:0] divider;
    logic        clock_phase;
    logic        clock_polarity;
    logic        MISO;
    logic        SCK;
    logic [31:0] data_read;
    logic        busy;
    logic        SS;
    logic        MOSI;
    logic        data_read_valid;

    spi_master_if #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .data            (data),
        .address         (address),
        .enable          (enable),
        .rd_we           (rd_we),
        .divider         (divider),
        .clock_phase     (clock_phase),
        .clock_polarity  (clock_polarity),
        .MISO            (MISO),
        .SCK             (SCK),
        .data_read       (data_read),
        .busy            (busy),
        .SS              (SS),
        .MOSI            (MOSI),
        .data_read_valid (data_read_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        logic [32:0] cmd_addr;
        logic [31:0] data_field;
        int          cycles;
        logic        is_read;
        logic [31:0] rdata;
        logic        abort;
        logic        first_mosi;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Slave model + monitor
    // -------------------------------------------------------------------------
    logic [31:0] mem [logic [31:0]];
    logic        mode_cpol = 1'b0;
    logic        mode_cpha = 1'b0;
    logic        sck_prev = 1'b0;
    logic        ss_prev = 1'b1;
    logic [64:0] rx = '0;
    int          bitcnt = 0;
    int          edges = 0;
    int          busy_cycles = 0;
    int          ss_err = 0;
    logic        first_mosi = 1'b0;
    logic [31:0] tx_word = '0;
    logic        miso_r = 1'b0;
    logic        pending = 1'b0;
    logic        frame_end;
    logic        lead;
    logic        samp;
    exp_t        e;

    assign MISO = miso_r;

    always @(negedge clock) begin
        frame_end = SS && !ss_prev;
        if (ss_prev && !SS) begin
            busy_cycles = 0;
            edges       = 0;
            bitcnt      = 0;
            rx          = '0;
            first_mosi  = MOSI;
            ss_err      = 0;
            tx_word     = '0;
            miso_r      = 1'b0;
        end
        if (busy) busy_cycles++;
        if (SS !== !busy) ss_err++;

        if (!SS && (SCK != sck_prev)) begin
            edges++;
            lead = (SCK != mode_cpol);
            samp = mode_cpha ? !lead : lead;
            if (samp) begin
                rx = {rx[63:0], MOSI};
                bitcnt++;
                if (bitcnt == 33) tx_word = mem.exists(rx[31:0]) ? mem[rx[31:0]] : 32'h0;
            end else begin
                if (bitcnt >= 33 && bitcnt < 65) miso_r = tx_word[64 - bitcnt];
                else miso_r = 1'b0;
            end
        end

        if (frame_end) begin
            miso_r = 1'b0;
            if (sb.size() == 0) begin
                check("unexpected_frame", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                if (e.abort) begin
                    check("abort_no_valid", 64'(data_read_valid), 64'(0));
                    check("abort_busy", 64'(busy), 64'(0));
                end else begin
                    check("frame_cmd_addr", 64'(rx[64:32]), 64'(e.cmd_addr));
                    check("frame_data", 64'(rx[31:0]), 64'(e.data_field));
                    check("sck_edges", 64'(edges), 64'(130));
                    check("busy_cycles", 64'(busy_cycles), 64'(e.cycles));
                    check("first_mosi", 64'(first_mosi), 64'(e.first_mosi));
                    check("ss_tracks_busy", 64'(ss_err), 64'(0));
                    check("mosi_after_end", 64'(MOSI), 64'(0));
                    check("valid_at_end", 64'(data_read_valid), 64'(e.is_read));
                    if (e.is_read) check("data_read", 64'(data_read), 64'(e.rdata));
                    if (rx[64] && edges == 130) mem[rx[63:32]] = rx[31:0];
                    pending = 1'b1;
                end
            end
        end else if (pending) begin
            check("valid_one_cycle", 64'(data_read_valid), 64'(0));
            pending = 1'b0;
        end else if (data_read_valid) begin
            check("stray_valid", 64'(data_read_valid), 64'(0));
        end

        sck_prev = SCK;
        ss_prev  = SS;
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic start_frame(input logic wr, input logic [31:0] addr, input logic [31:0] dat,
                               input logic [15:0] div, input logic cpol, input logic cpha,
                               input logic [31:0] rexp, input logic abort);
        exp_t x;
        int   d;
        d            = (div == 16'd0) ? 1 : int'(div);
        x.cmd_addr   = {wr, addr};
        x.data_field = wr ? dat : 32'h0;
        x.cycles     = 131 * d;
        x.is_read    = !wr;
        x.rdata      = rexp;
        x.abort      = abort;
        x.first_mosi = cpha ? 1'b0 : wr;
        sb.push_back(x);

        @(posedge clock); #1;
        mode_cpol      = cpol;
        mode_cpha      = cpha;
        clock_polarity = cpol;
        clock_phase    = cpha;
        rd_we          = wr;
        address        = addr;
        data           = dat;
        divider        = div;
        enable         = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0;
        check("busy_rise", 64'(busy), 64'(1));
        check("ss_fall", 64'(SS), 64'(0));
        // Scramble everything except polarity; the frame must not notice.
        data        = ~dat;
        address     = ~addr;
        rd_we       = ~wr;
        divider     = div + 16'd5;
        clock_phase = ~cpha;
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clock);
            n++;
        end
        check("frame_timeout", 64'(busy), 64'(0));
        repeat (3) @(posedge clock);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        reset          = 1'b1;
        data           = '0;
        address        = '0;
        enable         = 1'b0;
        rd_we          = 1'b0;
        divider        = 16'd2;
        clock_phase    = 1'b0;
        clock_polarity = 1'b0;
        mem[32'h20]    = 32'h3C3C5AA5;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ss", 64'(SS), 64'(1));
        check("rst_mosi", 64'(MOSI), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_data_read", 64'(data_read), 64'(0));
        check("rst_valid", 64'(data_read_valid), 64'(0));
        check("rst_sck_cpol0", 64'(SCK), 64'(0));
        clock_polarity = 1'b1;
        #1;
        check("rst_sck_cpol1", 64'(SCK), 64'(1));
        clock_polarity = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // Mode 0 write, then mode 0 read.
        start_frame(1'b1, 32'h10, 32'hA5A5A5A5, 16'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_done();
        start_frame(1'b0, 32'h20, 32'h0, 16'd2, 1'b0, 1'b0, 32'h3C3C5AA5, 1'b0);
        wait_done();

        // Mode 3 round trip at divider 1.
        clock_polarity = 1'b1;
        #1;
        check("mode3_sck_idle_pre", 64'(SCK), 64'(1));
        start_frame(1'b1, 32'h44, 32'hDEADBEEF, 16'd1, 1'b1, 1'b1, 32'h0, 1'b0);
        wait_done();
        start_frame(1'b0, 32'h44, 32'h0, 16'd1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        wait_done();
        check("mode3_sck_idle_post", 64'(SCK), 64'(1));

        // enable pulsed mid-frame is ignored (mode 1).
        start_frame(1'b1, 32'h55, 32'h0F0F1234, 16'd2, 1'b0, 1'b1, 32'h0, 1'b0);
        repeat (48) @(posedge clock);
        #1;
        data    = 32'hFFFFFFFF;
        address = 32'h99;
        rd_we   = 1'b0;
        enable  = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0;
        wait_done();
        repeat (5) @(posedge clock);
        #1;
        check("no_second_frame", 64'(busy), 64'(0));

        // Reset mid-frame (mode 2 read), then a normal frame.
        start_frame(1'b0, 32'h20, 32'h0, 16'd2, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (40) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("abort_ss", 64'(SS), 64'(1));
        check("abort_sck", 64'(SCK), 64'(1));
        check("abort_busy_now", 64'(busy), 64'(0));
        check("abort_mosi", 64'(MOSI), 64'(0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        start_frame(1'b0, 32'h44, 32'h0, 16'd3, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
        wait_done();

        // divider 0 behaves as divider 1.
        clock_polarity = 1'b0;
        start_frame(1'b1, 32'h7, 32'h12345678, 16'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_done();
        start_frame(1'b0, 32'h7, 32'h0, 16'd1, 1'b0, 1'b0, 32'h12345678, 1'b0);
        wait_done();

        repeat (5) @(posedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master_if.md
# spi_master_if

SPI bus master that serialises one command/address/data frame per request from a parallel host interface. It sits between an on-chip register/bus client and an external or on-chip SPI slave (`spi_slave`, a separate block). It supports all four CPOL/CPHA modes and a programmable SCK divider. For reads, it returns the slave's data word with a one-cycle valid strobe.

## Interface
- DATA_WIDTH, 32, width of data word shifted per frame
- ADDRESS_WIDTH, 32, width of address field shifted per frame
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- data  in  DATA_WIDTH  write data; latched on accepted request
- address  in  ADDRESS_WIDTH  target address; latched on accepted request
- enable  in  1  request strobe; one cycle is sufficient
- rd_we  in  1  1 = write, 0 = read; latched with request
- divider  in  16  SCK half-period in clock cycles; 0 is treated as 1
- clock_phase  in  1  CPHA
- clock_polarity  in  1  CPOL (SCK idle level)
- MISO  in  1  serial data from slave
- SCK  out  1  serial clock
- data_read  out  DATA_WIDTH  last word read from slave
- busy  out  1  transaction in progress
- SS  out  1  slave select, active-low
- MOSI  out  1  serial data to slave
- data_read_valid  out  1  one-cycle pulse when data_read is updated

## Operation
- Reset values:
  - SS=1, MOSI=0, busy=0, data_read=0, data_read_valid=0.
  - Internal phase=0, so SCK=clock_polarity.
- Frame: N = 1 + ADDRESS_WIDTH + DATA_WIDTH bits, MSB first.
  - Bit 0 is the command bit (rd_we).
  - Next comes address[ADDRESS_WIDTH-1:0].
  - Last come DATA_WIDTH data bits.
- Write (rd_we=1): the data field carries the latched data on MOSI. MISO is ignored, data_read is unchanged, and there is no valid pulse.
- Read (rd_we=0): MOSI=0 during the data field. MISO is sampled for the DATA_WIDTH data bits only, shifted in MSB first.
- States:
  - IDLE: SCK follows the live clock_polarity input.
  - ACTIVE: shifting the frame.
  - END: SCK idle, SS still low for one half-period.
  - Then back to IDLE.
- IDLE to ACTIVE on enable=1 with busy=0:
  - Latch data, address, rd_we, divider, CPOL and CPHA.
  - Assert SS=0 and busy=1.
- SCK = latched CPOL XOR internal phase, toggling every divider cycles during ACTIVE. There are 2N edges in total.
- CPHA=0:
  - MOSI presents bit 0 when SS falls.
  - Data is sampled on each leading (odd) edge.
  - MOSI advances on each trailing edge except the last.
- CPHA=1:
  - MOSI=0 until the first leading edge.
  - MOSI advances on each leading edge.
  - Data is sampled on each trailing edge.
- enable while busy=1 is ignored (not queued).
- Inputs changing mid-frame have no effect (all are latched).
- Reset mid-frame aborts immediately: all outputs return to reset values and no valid pulse is issued.
- After END, MOSI returns to 0.

## Timing
- Let request edge T be the rising edge where enable=1 and busy=0 are sampled. Let D = max(divider, 1).
- Edge T:
  - busy=1 and SS=0.
  - MOSI = bit 0 if CPHA=0, else MOSI = 0.
- SCK edge k (k = 1..2N) occurs at T + k·D.
- SS returns to 1 and busy returns to 0 at T + (2N+1)·D.
- For reads, data_read updates and data_read_valid=1 on that same edge; data_read_valid=0 on the next edge.
- busy is continuous from T to the end of the frame. A new enable is accepted on the first edge where busy=0.
- With 32/32 widths: N=65. The frame lasts 131·D cycles, i.e. 262 cycles at divider=2.

## Test plan
- Mode 0, write:
  - Stimulus: divider=2, address=0x10, data=0xA5A5A5A5, rd_we=1, one-cycle enable.
  - MOSI sampled on SCK rising edges reads 1, then 0x00000010, then 0xA5A5A5A5.
  - busy is high for 262 cycles, SS is low throughout, and there is no data_read_valid.
- Mode 0, read:
  - Stimulus: divider=2, rd_we=0, slave model returns 0x3C3C5AA5.
  - MOSI command bit = 0 and the data field is all 0.
  - data_read=0x3C3C5AA5 with a single-cycle data_read_valid coincident with busy falling.
- Mode 3 read/write round trip:
  - Stimulus: CPOL=1, CPHA=1, divider=1. Write 0xDEADBEEF to slave, then read it back.
  - SCK idles high.
  - data_read=0xDEADBEEF.
  - Each frame lasts 131 cycles.
- enable pulsed again 50 cycles into a frame: ignored. Exactly one frame of 2N SCK edges occurs.
- Reset asserted mid-frame:
  - SS=1, SCK=CPOL, busy=0, MOSI=0 immediately.
  - No valid pulse.
  - A subsequent request completes normally.
- divider=0 behaves identically to divider=1, with a frame of 131 cycles.
